// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: walks IDLE -> F1 -> F2 -> F3 -> EXEC and back,
// raising the datapath strobes that move PC->MAR, M->MDR and MDR->IR, applying
// PC redirects at the end of EXEC, and latching a sticky FAULT on a memory
// timeout, an illegal redirect source or an unreachable state encoding.
//
// Ports
//   i_CLK            system clock, all state changes on posedge
//   i_RST            synchronous active-high reset
//   i_Run            level, permits fetch to start (IDLE) or continue (EXEC exit)
//   i_Mem_Ready      memory read data valid this cycle
//   i_Exec_Done      execute phase of the current instruction complete
//   i_Redirect_Valid PC redirect request, only looked at with i_Exec_Done in EXEC
//   i_Redirect_Src   redirect PC mux source (01 bus, 10 adder)
//   o_LD_PC/o_PCMUX  PC load enable and PC mux select (00 PC+1, 01 bus, 10 adder)
//   o_GatePC, o_LD_MAR, o_Mem_En, o_LD_MDR, o_GateMDR, o_LD_IR  datapath strobes
//   o_Fetch_Done     one-cycle pulse in the cycle IR is loaded
//   o_Fault          sticky fault flag
//   o_State          current state encoding
module fetch_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic       i_CLK,
  input  logic       i_RST,
  input  logic       i_Run,
  input  logic       i_Mem_Ready,
  input  logic       i_Exec_Done,
  input  logic       i_Redirect_Valid,
  input  logic [1:0] i_Redirect_Src,
  output logic       o_LD_PC,
  output logic [1:0] o_PCMUX,
  output logic       o_GatePC,
  output logic       o_LD_MAR,
  output logic       o_Mem_En,
  output logic       o_LD_MDR,
  output logic       o_GateMDR,
  output logic       o_LD_IR,
  output logic       o_Fetch_Done,
  output logic       o_Fault,
  output logic [2:0] o_State
);

  localparam int unsigned CNT_W     = 8;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_F1    = 3'd1,
    ST_F2    = 3'd2,
    ST_F3    = 3'd3,
    ST_EXEC  = 3'd4,
    ST_FAULT = 3'd5
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic             redirect_req;
  logic             redirect_ok;
  logic             redirect_bad;

  // Redirect is only meaningful at the EXEC exit; split legal/illegal sources.
  assign redirect_req = (state == ST_EXEC) && i_Exec_Done && i_Redirect_Valid;
  assign redirect_ok  = redirect_req && (i_Redirect_Src == 2'b01 || i_Redirect_Src == 2'b10);
  assign redirect_bad = redirect_req && (i_Redirect_Src == 2'b00 || i_Redirect_Src == 2'b11);

  // State register and F2 wait counter; the counter is held at zero outside F2.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
    end else begin
      wait_cnt <= '0;
      case (state)
        ST_IDLE: begin
          if (i_Run) state <= ST_F1;
        end
        ST_F1: begin
          state <= ST_F2;
        end
        ST_F2: begin
          // Ready is still accepted in the last allowed wait cycle.
          if (i_Mem_Ready) begin
            state <= ST_F3;
          end else if (wait_cnt == WAIT_LAST) begin
            state <= ST_FAULT;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        ST_F3: begin
          state <= ST_EXEC;
        end
        ST_EXEC: begin
          if (i_Exec_Done) begin
            if (redirect_bad) state <= ST_FAULT;
            else if (i_Run)   state <= ST_F1;
            else              state <= ST_IDLE;
          end
        end
        ST_FAULT: begin
          state <= ST_FAULT;
        end
        default: begin
          state <= ST_FAULT;
        end
      endcase
    end
  end

  // Output decode of the state register; strobes are suppressed while reset is sampled.
  always_comb begin
    o_LD_PC      = 1'b0;
    o_PCMUX      = 2'b00;
    o_GatePC     = 1'b0;
    o_LD_MAR     = 1'b0;
    o_Mem_En     = 1'b0;
    o_LD_MDR     = 1'b0;
    o_GateMDR    = 1'b0;
    o_LD_IR      = 1'b0;
    o_Fetch_Done = 1'b0;
    o_Fault      = (state == ST_FAULT);
    o_State      = state;
    if (!i_RST) begin
      case (state)
        ST_F1: begin
          o_GatePC = 1'b1;
          o_LD_MAR = 1'b1;
          o_LD_PC  = 1'b1;
        end
        ST_F2: begin
          o_Mem_En = 1'b1;
          o_LD_MDR = i_Mem_Ready;
        end
        ST_F3: begin
          o_GateMDR    = 1'b1;
          o_LD_IR      = 1'b1;
          o_Fetch_Done = 1'b1;
        end
        ST_EXEC: begin
          if (redirect_ok) begin
            o_LD_PC = 1'b1;
            o_PCMUX = i_Redirect_Src;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer with directed scenarios and a
// randomized run compared against a behavioural model of the fetch rules.
module tb_fetch_sequencer;

  localparam int unsigned T = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b0;
  logic       mem_ready = 1'b0;
  logic       exec_done = 1'b0;
  logic       redir_valid = 1'b0;
  logic [1:0] redir_src = 2'b00;

  logic       ld_pc, gate_pc, ld_mar, mem_en, ld_mdr, gate_mdr, ld_ir, fetch_done, fault;
  logic [1:0] pcmux;
  logic [2:0] state;

  fetch_sequencer #(.TIMEOUT_CYCLES(T)) dut (
    .i_CLK(clk), .i_RST(rst), .i_Run(run), .i_Mem_Ready(mem_ready),
    .i_Exec_Done(exec_done), .i_Redirect_Valid(redir_valid), .i_Redirect_Src(redir_src),
    .o_LD_PC(ld_pc), .o_PCMUX(pcmux), .o_GatePC(gate_pc), .o_LD_MAR(ld_mar),
    .o_Mem_En(mem_en), .o_LD_MDR(ld_mdr), .o_GateMDR(gate_mdr), .o_LD_IR(ld_ir),
    .o_Fetch_Done(fetch_done), .o_Fault(fault), .o_State(state)
  );

  always #5 clk = ~clk;

  // {LD_PC, PCMUX[1:0], GatePC, LD_MAR, Mem_En, LD_MDR, GateMDR, LD_IR, Fetch_Done, Fault, State[2:0]}
  logic [13:0] obs;
  assign obs = {ld_pc, pcmux, gate_pc, ld_mar, mem_en, ld_mdr, gate_mdr, ld_ir, fetch_done, fault, state};

  int checks = 0;
  int fails  = 0;
  logic [13:0] exp_o;

  // Behavioural model: phase 0 idle, 1 addr, 2 mem wait, 3 IR load, 4 exec, 5 fault.
  int m_phase  = 0;
  int m_waited = 0;

  function automatic logic legal_src(input logic [1:0] s);
    return (s == 2'b01) || (s == 2'b10);
  endfunction

  function automatic logic [13:0] model_out();
    logic live, redir;
    live  = !rst;
    redir = live && m_phase == 4 && exec_done && redir_valid && legal_src(redir_src);
    return {live && (m_phase == 1 || redir), (redir ? redir_src : 2'b00),
            live && m_phase == 1, live && m_phase == 1,
            live && m_phase == 2, live && m_phase == 2 && mem_ready,
            live && m_phase == 3, live && m_phase == 3, live && m_phase == 3,
            m_phase == 5, 3'(m_phase)};
  endfunction

  // Advance the model by one clock using the inputs held across that edge.
  task automatic model_update();
    if (rst) begin
      m_phase = 0; m_waited = 0;
    end else if (m_phase == 0) begin
      if (run) m_phase = 1;
    end else if (m_phase == 1) begin
      m_phase = 2; m_waited = 0;
    end else if (m_phase == 2) begin
      if (mem_ready) m_phase = 3;
      else begin
        m_waited = m_waited + 1;
        if (m_waited == int'(T)) m_phase = 5;
      end
    end else if (m_phase == 3) begin
      m_phase = 4;
    end else if (m_phase == 4) begin
      if (exec_done) begin
        if (redir_valid && !legal_src(redir_src)) m_phase = 5;
        else m_phase = run ? 1 : 0;
      end
    end
  endtask

  // Drive one cycle of inputs at the falling edge; outputs settle by +1.
  task automatic drive(input logic r, input logic ru, input logic rd, input logic d,
                       input logic v, input logic [1:0] s);
    model_update();
    @(negedge clk);
    rst = r; run = ru; mem_ready = rd; exec_done = d; redir_valid = v; redir_src = s;
    #1;
    exp_o = model_out();
  endtask

  task automatic fetch_to_exec();
    drive(0, 1, 0, 0, 0, 2'b00);
    drive(0, 1, 0, 0, 0, 2'b00);
    drive(0, 1, 1, 0, 0, 2'b00);
    drive(0, 1, 0, 0, 0, 2'b00);
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      drive(1, 1, 1, 1, 1, 2'b10);
      checks++;
      if (obs[13:4] !== 10'd0) begin
        fails++; $display("FAIL reset_strobes cycle %0d: obs=%h want strobes 0", k, obs);
      end
    end
    drive(0, 0, 0, 0, 0, 2'b00);
    checks++;
    if (obs !== 14'd0) begin
      fails++; $display("FAIL reset_state: obs=%h want 0000", obs);
    end
  endtask

  task automatic test_basic_fetch();
    int seq [5] = '{0, 1, 2, 3, 4};
    int n_ldpc = 0, n_fd = 0;
    for (int k = 0; k < 5; k++) begin
      drive(0, 1, 1, 0, 0, 2'b00);
      checks++;
      if (obs !== exp_o || state !== 3'(seq[k])) begin
        fails++; $display("FAIL basic_fetch cycle %0d: obs=%h want %h state %0d", k, obs, exp_o, seq[k]);
      end
      if (ld_pc) n_ldpc++;
      if (fetch_done) n_fd++;
    end
    checks++;
    if (n_ldpc != 1 || n_fd != 1) begin
      fails++; $display("FAIL basic_pulses: ld_pc=%0d fetch_done=%0d want 1 and 1", n_ldpc, n_fd);
    end
    drive(0, 0, 0, 1, 0, 2'b00);
    drive(0, 0, 0, 0, 0, 2'b00);
    checks++;
    if (obs !== exp_o || state !== 3'd0) begin
      fails++; $display("FAIL basic_return_idle: obs=%h want %h", obs, exp_o);
    end
  endtask

  task automatic test_timeout();
    drive(0, 1, 0, 0, 0, 2'b00);
    drive(0, 0, 0, 0, 0, 2'b00);
    for (int k = 0; k < int'(T); k++) begin
      drive(0, 0, 0, 0, 0, 2'b00);
      checks++;
      if (obs !== exp_o || state !== 3'd2) begin
        fails++; $display("FAIL timeout_wait cycle %0d: obs=%h want %h", k, obs, exp_o);
      end
    end
    drive(0, 1, 1, 1, 1, 2'b01);
    checks++;
    if (state !== 3'd5 || fault !== 1'b1 || obs[13:4] !== 10'd0) begin
      fails++; $display("FAIL timeout_fault: obs=%h want state 5 fault 1", obs);
    end
    drive(1, 0, 0, 0, 0, 2'b00);
    drive(0, 0, 0, 0, 0, 2'b00);
    checks++;
    if (obs !== 14'd0) begin
      fails++; $display("FAIL timeout_reset: obs=%h want 0000", obs);
    end
  endtask

  task automatic test_timeout_edge();
    drive(0, 1, 0, 0, 0, 2'b00);
    drive(0, 0, 0, 0, 0, 2'b00);
    for (int k = 0; k < int'(T); k++) begin
      drive(0, 0, (k == int'(T) - 1), 0, 0, 2'b00);
      checks++;
      if (obs !== exp_o || state !== 3'd2) begin
        fails++; $display("FAIL edge_wait cycle %0d: obs=%h want %h", k, obs, exp_o);
      end
    end
    drive(0, 0, 0, 0, 0, 2'b00);
    checks++;
    if (state !== 3'd3 || fault !== 1'b0 || fetch_done !== 1'b1) begin
      fails++; $display("FAIL edge_ready_last: obs=%h want state 3 no fault", obs);
    end
    drive(0, 0, 0, 1, 0, 2'b00);
    drive(0, 0, 0, 0, 0, 2'b00);
    checks++;
    if (state !== 3'd0) begin
      fails++; $display("FAIL edge_return_idle: state=%0d want 0", state);
    end
  endtask

  task automatic test_redirect();
    fetch_to_exec();
    drive(0, 1, 0, 0, 1, 2'b10);
    checks++;
    if (ld_pc !== 1'b0 || state !== 3'd4 || obs !== exp_o) begin
      fails++; $display("FAIL redirect_ignored: obs=%h want %h", obs, exp_o);
    end
    drive(0, 1, 0, 1, 1, 2'b10);
    checks++;
    if (ld_pc !== 1'b1 || pcmux !== 2'b10 || obs !== exp_o) begin
      fails++; $display("FAIL redirect_adder: obs=%h want ld_pc 1 pcmux 10", obs);
    end
    drive(0, 1, 0, 0, 0, 2'b00);
    checks++;
    if (state !== 3'd1 || pcmux !== 2'b00 || ld_pc !== 1'b1) begin
      fails++; $display("FAIL redirect_next_f1: obs=%h want state 1", obs);
    end
    drive(0, 1, 1, 0, 0, 2'b00);
    drive(0, 1, 0, 0, 0, 2'b00);
    drive(0, 0, 0, 1, 1, 2'b01);
    checks++;
    if (ld_pc !== 1'b1 || pcmux !== 2'b01 || obs !== exp_o) begin
      fails++; $display("FAIL redirect_bus: obs=%h want ld_pc 1 pcmux 01", obs);
    end
    drive(0, 0, 0, 0, 0, 2'b00);
    checks++;
    if (state !== 3'd0) begin
      fails++; $display("FAIL redirect_to_idle: state=%0d want 0", state);
    end
  endtask

  task automatic test_bad_redirect();
    logic [1:0] srcs [2] = '{2'b11, 2'b00};
    for (int k = 0; k < 2; k++) begin
      fetch_to_exec();
      drive(0, 1, 0, 1, 1, srcs[k]);
      checks++;
      if (ld_pc !== 1'b0 || pcmux !== 2'b00 || obs !== exp_o) begin
        fails++; $display("FAIL bad_redirect src %0d: obs=%h want ld_pc 0", srcs[k], obs);
      end
      drive(0, 1, 1, 1, 1, 2'b10);
      drive(0, 1, 1, 1, 1, 2'b10);
      checks++;
      if (state !== 3'd5 || fault !== 1'b1 || obs[13:4] !== 10'd0) begin
        fails++; $display("FAIL bad_redirect_fault src %0d: obs=%h want state 5", srcs[k], obs);
      end
      drive(1, 1, 1, 1, 1, 2'b10);
      drive(0, 0, 0, 0, 0, 2'b00);
      checks++;
      if (obs !== 14'd0) begin
        fails++; $display("FAIL bad_redirect_reset src %0d: obs=%h want 0000", srcs[k], obs);
      end
    end
  endtask

  task automatic test_run_drop();
    int seq [7] = '{0, 1, 2, 2, 3, 4, 4};
    logic run_v [7] = '{1, 1, 1, 0, 0, 0, 0};
    logic rdy_v [7] = '{0, 0, 0, 1, 0, 0, 0};
    logic dn_v  [7] = '{0, 0, 0, 0, 0, 0, 1};
    for (int k = 0; k < 7; k++) begin
      drive(0, run_v[k], rdy_v[k], dn_v[k], 0, 2'b00);
      checks++;
      if (obs !== exp_o || state !== 3'(seq[k])) begin
        fails++; $display("FAIL run_drop cycle %0d: obs=%h want %h", k, obs, exp_o);
      end
    end
    drive(0, 0, 0, 0, 0, 2'b00);
    drive(0, 0, 0, 0, 0, 2'b00);
    checks++;
    if (state !== 3'd0 || obs[13:4] !== 10'd0) begin
      fails++; $display("FAIL run_drop_idle: obs=%h want idle", obs);
    end
  endtask

  task automatic test_reset_in_f2();
    drive(0, 1, 0, 0, 0, 2'b00);
    drive(0, 1, 0, 0, 0, 2'b00);
    drive(0, 1, 0, 0, 0, 2'b00);
    drive(1, 1, 1, 0, 0, 2'b00);
    checks++;
    if (obs[13:4] !== 10'd0 || state !== 3'd2) begin
      fails++; $display("FAIL reset_f2_strobes: obs=%h want no strobes in state 2", obs);
    end
    drive(0, 0, 1, 0, 0, 2'b00);
    checks++;
    if (state !== 3'd0 || ld_mdr !== 1'b0 || ld_ir !== 1'b0 || fetch_done !== 1'b0) begin
      fails++; $display("FAIL reset_f2_idle: obs=%h want idle", obs);
    end
  endtask

  task automatic test_random();
    int shown = 0;
    for (int k = 0; k < 3000; k++) begin
      drive(($urandom_range(0, 63) == 0), 1'($urandom), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 2) == 0), 1'($urandom), 2'($urandom));
      checks++;
      if (obs !== exp_o) begin
        fails++;
        if (shown < 20) begin
          shown++;
          $display("FAIL random cycle %0d: obs=%h want %h", k, obs, exp_o);
        end
      end
    end
    drive(1, 0, 0, 0, 0, 2'b00);
    drive(0, 0, 0, 0, 0, 2'b00);
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_timeout();
    test_timeout_edge();
    test_redirect();
    test_bad_redirect();
    test_run_drop();
    test_reset_in_f2();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
